// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-queue handshake between a queue head (master) and the UART transmitter (slave)
interface uart_tx_if;
   logic       in_available;
   logic [7:0] in_data;
   logic       in_ack;
   modport master(output in_available, output in_data, input in_ack);
   modport slave(input in_available, input in_data, output in_ack);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: drains a byte queue and sends each byte as an 8N1 frame, idle-high line
module uart_tx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_tx_if.slave   q,
   output logic       tx,
   output logic       busy
);
   localparam int CW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state;
   logic [7:0]    shift;
   logic [2:0]    idx;
   logic [CW-1:0] cnt;
   logic          eob;
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
      $error("uart_tx: CLKS_PER_BIT must be within 2..65535");
   end
   assign eob = cnt == LAST;
   // the pop is combinational so the queue sees it in the same cycle the byte is latched
   assign q.in_ack = rst_n && state == IDLE && q.in_available;
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         tx    <= 1'b1;
         busy  <= 1'b0;
         shift <= '0;
         idx   <= '0;
         cnt   <= '0;
      end else
         case (state)
            IDLE: if (q.in_available) begin
               shift <= q.in_data;
               cnt   <= '0;
               state <= START;
               tx    <= 1'b0;
               busy  <= 1'b1;
            end
            START: if (eob) begin
               cnt   <= '0;
               idx   <= '0;
               state <= DATA;
               tx    <= shift[0];
            end else cnt <= cnt + 1'b1;
            DATA: if (eob) begin
               cnt   <= '0;
               shift <= shift >> 1;
               idx   <= idx + 3'd1;
               state <= idx == 3'd7 ? STOP : DATA;
               tx    <= idx == 3'd7 ? 1'b1 : shift[1];
            end else cnt <= cnt + 1'b1;
            STOP: if (eob) begin
               cnt   <= '0;
               state <= IDLE;
               busy  <= 1'b0;
            end else cnt <= cnt + 1'b1;
         endcase
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx frames, handshake, reset and bit-period sweep
module tb_uart_tx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx2, tx3, tx104, tx4, b2, b3, b104, b4;
   logic [2:0] sav = '0;
   logic [7:0] sdat = '0;
   logic [3:0] stx, sbusy, sack;
   logic [7:0] q4[$];
   int         vecs = 0, miss = 0, cyc = 0;
   int         acks4 = 0, ack_run = 0, max_run = 0, viol = 0, lag = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   uart_tx_if i2();
   uart_tx_if i3();
   uart_tx_if i104();
   uart_tx_if i4();
   assign i2.in_available   = sav[0];
   assign i3.in_available   = sav[1];
   assign i104.in_available = sav[2];
   assign i2.in_data        = sdat;
   assign i3.in_data        = sdat;
   assign i104.in_data      = sdat;
   assign stx   = {tx4, tx104, tx3, tx2};
   assign sbusy = {b4, b104, b3, b2};
   assign sack  = {i4.in_ack, i104.in_ack, i3.in_ack, i2.in_ack};
   uart_tx #(.CLKS_PER_BIT(2))   dut2(.clk(clk), .rst_n(rst_n), .q(i2.slave), .tx(tx2), .busy(b2));
   uart_tx #(.CLKS_PER_BIT(3))   dut3(.clk(clk), .rst_n(rst_n), .q(i3.slave), .tx(tx3), .busy(b3));
   uart_tx #(.CLKS_PER_BIT(104)) dut104(.clk(clk), .rst_n(rst_n), .q(i104.slave), .tx(tx104), .busy(b104));
   uart_tx #(.CLKS_PER_BIT(4))   dut4(.clk(clk), .rst_n(rst_n), .q(i4.slave), .tx(tx4), .busy(b4));
   // queue model: pops on ack, flag and data stay stale for 2 cycles after each pop
   always @(negedge clk) begin
      if (i4.in_ack === 1'b1) begin
         acks4++;
         ack_run++;
         if (i4.in_available !== 1'b1) viol++;
         if (q4.size() > 0) void'(q4.pop_front());
         lag = 2;
      end else ack_run = 0;
      if (ack_run > max_run) max_run = ack_run;
   end
   always @(posedge clk) begin
      #2;
      if (lag > 0) lag--;
      else begin
         i4.in_available = q4.size() > 0;
         i4.in_data      = q4.size() > 0 ? q4[0] : 8'h00;
      end
   end
   task automatic observe(input int k, input int c, input logic [7:0] exp,
                          output int st, output int len, output int bad, output logic [7:0] got);
      int   t;
      int   i;
      logic e;
      t = 0; len = 0; bad = 0; got = '0; st = -1;
      @(negedge clk);
      while (stx[k] !== 1'b0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (stx[k] !== 1'b0) return;
      st = cyc;
      while (sbusy[k] === 1'b1 && len < 20000) begin
         i = len / c;
         e = i == 0 ? 1'b0 : i >= 9 ? 1'b1 : exp[i-1];
         if (stx[k] !== e) bad++;
         if (i >= 1 && i <= 8 && len % c == c / 2) got[i-1] = stx[k];
         len++;
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      int         st, len, bad;
      logic [7:0] got;
      q4.push_back(8'h55);
      repeat (3) begin
         @(negedge clk);
         vecs += 3;
         if (tx4 !== 1'b1) begin miss++; $display("FAIL reset_tx: got %b want 1", tx4); end
         if (b4 !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", b4); end
         if (i4.in_ack !== 1'b0) begin miss++; $display("FAIL reset_ack: got %b want 0", i4.in_ack); end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      observe(3, 4, 8'h55, st, len, bad, got);
      repeat (3) @(negedge clk);
      vecs++;
      if (acks4 !== 1) begin miss++; $display("FAIL reset_release_acks: got %0d want 1", acks4); end
   endtask
   task automatic test_single_byte;
      int         a0, st, len, bad;
      logic [7:0] got;
      a0 = acks4;
      @(posedge clk); #1 q4.push_back(8'h55);
      observe(3, 4, 8'h55, st, len, bad, got);
      vecs += 3;
      if (len !== 40) begin miss++; $display("FAIL single_busy_len: got %0d want 40", len); end
      if (bad !== 0) begin miss++; $display("FAIL single_pattern: got %0d bad cycles want 0", bad); end
      if (got !== 8'h55) begin miss++; $display("FAIL single_byte: got %h want 55", got); end
      repeat (5) @(negedge clk);
      vecs += 3;
      if (acks4 - a0 !== 1) begin miss++; $display("FAIL single_acks: got %0d want 1", acks4 - a0); end
      if (max_run !== 1) begin miss++; $display("FAIL single_ack_width: got %0d want 1", max_run); end
      if (tx4 !== 1'b1 || b4 !== 1'b0) begin miss++; $display("FAIL single_idle: got tx=%b busy=%b want 1 0", tx4, b4); end
   endtask
   task automatic test_back_to_back;
      int         a0, s1, s2, l1, l2, bd1, bd2, nb;
      logic [7:0] g1, g2;
      a0 = acks4;
      @(posedge clk); #1 begin q4.push_back(8'hA3); q4.push_back(8'h0F); end
      observe(3, 4, 8'hA3, s1, l1, bd1, g1);
      observe(3, 4, 8'h0F, s2, l2, bd2, g2);
      nb = 0;
      repeat (30) begin @(negedge clk); if (b4 !== 1'b0) nb++; end
      vecs += 6;
      if (g1 !== 8'hA3 || bd1 !== 0 || l1 !== 40) begin miss++; $display("FAIL b2b_first: got %h bad=%0d len=%0d want a3 0 40", g1, bd1, l1); end
      if (g2 !== 8'h0F || bd2 !== 0 || l2 !== 40) begin miss++; $display("FAIL b2b_second: got %h bad=%0d len=%0d want 0f 0 40", g2, bd2, l2); end
      if (s2 - s1 !== 41) begin miss++; $display("FAIL b2b_period: got %0d want 41", s2 - s1); end
      if (acks4 - a0 !== 2) begin miss++; $display("FAIL b2b_acks: got %0d want 2", acks4 - a0); end
      if (q4.size() !== 0) begin miss++; $display("FAIL b2b_queue_empty: got %0d want 0", q4.size()); end
      if (nb !== 0) begin miss++; $display("FAIL b2b_no_third: got %0d busy cycles want 0", nb); end
   endtask
   task automatic test_empty;
      int a0, nt, nb, na;
      a0 = acks4; nt = 0; nb = 0; na = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx4 !== 1'b1) nt++;
         if (b4 !== 1'b0) nb++;
         if (i4.in_ack !== 1'b0) na++;
      end
      vecs += 4;
      if (nt !== 0) begin miss++; $display("FAIL empty_tx: got %0d low cycles want 0", nt); end
      if (nb !== 0) begin miss++; $display("FAIL empty_busy: got %0d busy cycles want 0", nb); end
      if (na !== 0 || acks4 !== a0) begin miss++; $display("FAIL empty_ack: got %0d want 0", na); end
      if (viol !== 0) begin miss++; $display("FAIL ack_without_available: got %0d want 0", viol); end
   endtask
   task automatic test_midframe_reset;
      int         a0, t, st, len, bad;
      logic [7:0] got;
      a0 = acks4; t = 0;
      @(posedge clk); #1 q4.push_back(8'hFF);
      @(negedge clk);
      while (tx4 !== 1'b0 && t < 50) begin @(negedge clk); t++; end
      vecs++;
      if (tx4 !== 1'b0) begin miss++; $display("FAIL mid_start: got tx=%b want 0", tx4); end
      repeat (16) @(negedge clk);
      @(posedge clk); #1 begin q4.push_back(8'h81); rst_n = 1'b0; end
      @(negedge clk);
      vecs++;
      if (i4.in_ack !== 1'b0) begin miss++; $display("FAIL mid_ack_in_data: got %b want 0", i4.in_ack); end
      @(negedge clk);
      vecs += 2;
      if (tx4 !== 1'b1 || b4 !== 1'b0) begin miss++; $display("FAIL mid_abort: got tx=%b busy=%b want 1 0", tx4, b4); end
      if (i4.in_ack !== 1'b0) begin miss++; $display("FAIL mid_ack_in_reset: got %b want 0", i4.in_ack); end
      @(posedge clk); #1 rst_n = 1'b1;
      observe(3, 4, 8'h81, st, len, bad, got);
      repeat (5) @(negedge clk);
      vecs += 2;
      if (got !== 8'h81 || bad !== 0 || len !== 40) begin miss++; $display("FAIL mid_next_frame: got %h bad=%0d len=%0d want 81 0 40", got, bad, len); end
      if (acks4 - a0 !== 2) begin miss++; $display("FAIL mid_acks: got %0d want 2", acks4 - a0); end
   endtask
   task automatic test_stale;
      int         a0, st, len, bad, nb;
      logic [7:0] got;
      a0 = acks4; nb = 0;
      @(posedge clk); #1 q4.push_back(8'h42);
      observe(3, 4, 8'h42, st, len, bad, got);
      repeat (60) begin @(negedge clk); if (b4 !== 1'b0) nb++; end
      vecs += 3;
      if (got !== 8'h42 || bad !== 0 || len !== 40) begin miss++; $display("FAIL stale_frame: got %h bad=%0d len=%0d want 42 0 40", got, bad, len); end
      if (acks4 - a0 !== 1) begin miss++; $display("FAIL stale_acks: got %0d want 1", acks4 - a0); end
      if (nb !== 0) begin miss++; $display("FAIL stale_second_frame: got %0d busy cycles want 0", nb); end
   endtask
   task automatic test_sweep;
      int         cs[3] = '{2, 3, 104};
      int         t, st, len, bad;
      logic [7:0] got;
      for (int k = 0; k < 3; k++) begin
         t = 0;
         @(posedge clk); #1 begin sav[k] = 1'b1; sdat = 8'h55; end
         @(negedge clk);
         while (sack[k] !== 1'b1 && t < 10) begin @(negedge clk); t++; end
         vecs++;
         if (sack[k] !== 1'b1) begin miss++; $display("FAIL sweep_ack_%0d: got %b want 1", cs[k], sack[k]); end
         @(posedge clk); #1 sav[k] = 1'b0;
         observe(k, cs[k], 8'h55, st, len, bad, got);
         vecs += 2;
         if (len !== 10 * cs[k]) begin miss++; $display("FAIL sweep_len_%0d: got %0d want %0d", cs[k], len, 10 * cs[k]); end
         if (bad !== 0 || got !== 8'h55) begin miss++; $display("FAIL sweep_pattern_%0d: got %h bad=%0d want 55 0", cs[k], got, bad); end
      end
   endtask
   initial begin
      i4.in_available = 1'b0;
      i4.in_data = 8'h00;
      test_reset;
      test_single_byte;
      test_back_to_back;
      test_empty;
      test_midframe_reset;
      test_stale;
      test_sweep;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
